// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: round count, key width, the expander
// FSM state encoding and the round-key type.
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_KEY_W = 128;

    typedef logic [AES_KEY_W-1:0] aes_rkey_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } aes_kx_state_t;

endpackage

// File: rtl/aes_key_store.sv
// Round-key register file: NUM_KEYS x 128 bits, one write port, one
// combinational read port, synchronous clear. Reads past the last entry
// return zero so the consumer sees a defined value for any 4-bit index.
module aes_key_store
    import aes_pkg::*;
#(
    parameter int NUM_KEYS = AES_NR + 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_we,
    input  logic [3:0] i_waddr,
    input  aes_rkey_t  i_wdata,
    input  logic [3:0] i_raddr,
    output aes_rkey_t  o_rdata
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_KEYS - 1);

    aes_rkey_t r_mem [NUM_KEYS];

    // Write port with synchronous clear of every entry.
    // NOTE: the store is cleared on reset on purpose: an aborted schedule must
    // not leave stale round keys visible on the read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr <= LAST_IDX)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Combinational read; out-of-range indices read as zero.
    // NOTE: o_rdata gets a default first so no path through this block can
    // leave it unassigned and infer a latch.
    always_comb begin
        o_rdata = '0;
        if (i_raddr <= LAST_IDX) begin
            o_rdata = r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/aes_key_expander.sv
// AES-128 key-schedule controller. Accepts a cipher key over valid/ready,
// drives an external single-round key step NUM_ROUNDS times and stores all
// NUM_ROUNDS+1 round keys for the round datapath to read by index.
// Optional feature macro: AES_KEY_CACHE_EN -- when defined, reloading the key
// already held in store[0] while in DONE is accepted without recomputation.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [127:0] key_in,
    output logic        keys_ready,
    input  logic [3:0]  rk_idx,
    output logic [127:0] rk_out,
    output logic        step_start,
    output logic [3:0]  step_rc,
    output logic [127:0] step_key,
    input  logic        step_done,
    input  logic [127:0] step_key_out
);

    localparam logic [3:0] RC_LAST = 4'(NUM_ROUNDS - 1);

    aes_kx_state_t r_state;
    logic [3:0]    r_rc;
    logic          r_keys_ready;
    logic          r_step_start;
    aes_rkey_t     r_step_key;

    logic          w_hit;
    logic          w_load;
    logic          w_we;
    logic [3:0]    w_waddr;
    aes_rkey_t     w_wdata;

`ifdef AES_KEY_CACHE_EN
    // Copy of store[0]; only compared in DONE, which is reachable solely
    // after a complete expansion, so the cleared reset value never hits.
    aes_rkey_t     r_cache_key;

    // Cache hit: same key offered while the finished schedule is held.
    always_comb begin
        w_hit = (r_state == ST_DONE) && (key_in == r_cache_key);
    end
`else
    // No cache: every accepted key is expanded.
    always_comb begin
        w_hit = 1'b0;
    end
`endif

    // Ready is combinational from state so IDLE/DONE accept in one cycle.
    always_comb begin
        key_ready = (r_state != ST_ROUND);
        w_load    = key_valid && key_ready && !w_hit;
    end

    // Store write mux: cipher key into entry 0 on load, step result into
    // entry rc+1 when the round step completes.
    always_comb begin
        w_we    = w_load;
        w_waddr = 4'd0;
        w_wdata = key_in;
        if (r_state == ST_ROUND) begin
            w_we    = step_done;
            w_waddr = r_rc + 4'd1;
            w_wdata = step_key_out;
        end
    end

    // Schedule FSM with registered step/status outputs. r_step_key mirrors
    // store[rc], so the step input needs no second store read port.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rc         <= 4'd0;
            r_keys_ready <= 1'b0;
            r_step_start <= 1'b0;
            r_step_key   <= '0;
`ifdef AES_KEY_CACHE_EN
            r_cache_key  <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_load) begin
                        r_state      <= ST_ROUND;
                        r_rc         <= 4'd0;
                        r_keys_ready <= 1'b0;
                        r_step_start <= 1'b1;
                        r_step_key   <= key_in;
`ifdef AES_KEY_CACHE_EN
                        r_cache_key  <= key_in;
`endif
                    end
                end
                ST_ROUND: begin
                    if (step_done) begin
                        if (r_rc == RC_LAST) begin
                            r_state      <= ST_DONE;
                            r_keys_ready <= 1'b1;
                            r_step_start <= 1'b0;
                        end else begin
                            r_rc       <= r_rc + 4'd1;
                            r_step_key <= step_key_out;
                        end
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_step_start <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        keys_ready = r_keys_ready;
        step_start = r_step_start;
        step_rc    = r_rc;
        step_key   = r_step_key;
    end

    aes_key_store #(
        .NUM_KEYS (NUM_ROUNDS + 1)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (rk_idx),
        .o_rdata (rk_out)
    );

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander. A table-driven round-step responder
// returns the FIPS-197 A.1 round keys with a programmable wait.
module tb_aes_key_expander;
    import aes_pkg::*;

    localparam aes_rkey_t FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam aes_rkey_t OTHER_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam aes_rkey_t STRAY_KEY = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    localparam aes_rkey_t BAD_KEY   = 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic        key_ready;
    aes_rkey_t   key_in;
    logic        keys_ready;
    logic [3:0]  rk_idx;
    aes_rkey_t   rk_out;
    logic        step_start;
    logic [3:0]  step_rc;
    aes_rkey_t   step_key;
    logic        step_done;
    aes_rkey_t   step_key_out;

    int          errors = 0;
    int          checks = 0;
    int          step_delay = 0;
    int          wait_cnt = 0;
    logic        stray_done = 1'b0;
    aes_rkey_t   fips_rk [0:10];

    always #5 clk = ~clk;

    aes_key_expander dut (
        .clk          (clk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_in       (key_in),
        .keys_ready   (keys_ready),
        .rk_idx       (rk_idx),
        .rk_out       (rk_out),
        .step_start   (step_start),
        .step_rc      (step_rc),
        .step_key     (step_key),
        .step_done    (step_done),
        .step_key_out (step_key_out)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic aes_rkey_t rk_ref(input int idx);
        if (idx >= 0 && idx <= 10) return fips_rk[idx];
        return BAD_KEY;
    endfunction

    // Round-step responder: answers after step_delay wait cycles.
    always_comb begin
        step_done    = stray_done || (step_start && (wait_cnt == step_delay));
        step_key_out = stray_done ? STRAY_KEY : rk_ref(int'(step_rc) + 1);
    end

    always @(posedge clk) begin
        if (rst || !step_start || step_done) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    // The key offered to the step must be the previous round key.
    always @(negedge clk) begin
        if (!rst && step_start && step_done && !stray_done)
            check($sformatf("step_key rc=%0d", step_rc), step_key, rk_ref(int'(step_rc)));
    end

    task automatic read_check(input int idx, input aes_rkey_t exp, input string tag);
        @(negedge clk);
        rk_idx = 4'(idx);
        #1;
        check($sformatf("%s rk[%0d]", tag, idx), rk_out, exp);
    endtask

    task automatic check_store(input string tag);
        for (int i = 0; i <= 10; i++) read_check(i, fips_rk[i], tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        key_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Load a key, optionally pulse a foreign key while rc==inject_rc, and
    // measure cycles from the load cycle until keys_ready.
    task automatic run_key(input aes_rkey_t key, input int delay, input int inject_rc,
                           input int exp_cycles, input string tag);
        int n;
        bit dropped;
        bit injected;
        step_delay = delay;
        @(negedge clk);
        check($sformatf("%s key_ready before load", tag), key_ready, 1);
        key_valid = 1'b1;
        key_in    = key;
        @(negedge clk);
        key_valid = 1'b0;
        n = 0;
        dropped = 0;
        injected = 0;
        while (!keys_ready && n < 2000) begin
            if (!step_start) dropped = 1;
            if (inject_rc >= 0 && !injected && step_rc == 4'(inject_rc)) begin
                key_valid = 1'b1;
                key_in    = OTHER_KEY;
                injected  = 1;
                check($sformatf("%s key_ready busy", tag), key_ready, 0);
            end
            @(negedge clk);
            key_valid = 1'b0;
            n++;
        end
        check($sformatf("%s latency", tag), n + 1, exp_cycles);
        check($sformatf("%s step_start held", tag), dropped, 0);
        check($sformatf("%s step_start low in done", tag), step_start, 0);
        check($sformatf("%s key_ready in done", tag), key_ready, 1);
        if (inject_rc >= 0) check($sformatf("%s injected", tag), injected, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        fips_rk = '{
            128'h2b7e151628aed2a6abf7158809cf4f3c,
            128'ha0fafe1788542cb123a339392a6c7605,
            128'hf2c295f27a96b9435935807a7359f67f,
            128'h3d80477d4716fe3e1e237e446d7a883b,
            128'hef44a541a8525b7fb671253bdb0bad00,
            128'hd4d1c6f87c839d87caf2b8bc11f915bc,
            128'h6d88a37a110b3efddbf98641ca0093fd,
            128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
            128'head27321b58dbad2312bf5607f8d292f,
            128'hac7766f319fadc2128d12941575c006e,
            128'hd014f9a8c9ee2589e13f0cc8b6630ca6
        };
        rst       = 1'b1;
        key_valid = 1'b0;
        key_in    = '0;
        rk_idx    = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset key_ready", key_ready, 1);
        check("reset keys_ready", keys_ready, 0);
        check("reset step_start", step_start, 0);
        check("reset step_rc", step_rc, 0);
        check("reset step_key", step_key, 0);
        check("reset rk_out", rk_out, 0);

        // Zero-wait expansion of the FIPS-197 key.
        run_key(FIPS_KEY, 0, -1, 11, "fips_d0");
        check_store("fips_d0");
        for (int i = 11; i <= 15; i++) read_check(i, '0, "oob");

        // step_done outside ROUND must not touch the store.
        @(negedge clk);
        stray_done = 1'b1;
        repeat (3) @(negedge clk);
        stray_done = 1'b0;
        check("stray keys_ready", keys_ready, 1);
        check("stray step_start", step_start, 0);
        read_check(1, fips_rk[1], "stray");
        read_check(10, fips_rk[10], "stray");

        // Reload of the same key while DONE.
`ifdef AES_KEY_CACHE_EN
        begin
            bit dropped;
            @(negedge clk);
            check("cache key_ready", key_ready, 1);
            key_valid = 1'b1;
            key_in    = FIPS_KEY;
            @(negedge clk);
            key_valid = 1'b0;
            dropped = 0;
            repeat (12) begin
                if (!keys_ready || step_start) dropped = 1;
                @(negedge clk);
            end
            check("cache keys_ready held", dropped, 0);
            check_store("cache");
        end
`else
        run_key(FIPS_KEY, 0, -1, 11, "reload");
        check_store("reload");
`endif

        // Three wait cycles per round, foreign key pulsed at round 4.
        do_reset();
        run_key(FIPS_KEY, 3, 4, 41, "fips_d3");
        check_store("fips_d3");

        // Reset at round 6 aborts and clears the store.
        do_reset();
        step_delay = 0;
        @(negedge clk);
        key_valid = 1'b1;
        key_in    = FIPS_KEY;
        @(negedge clk);
        key_valid = 1'b0;
        n = 0;
        while (step_rc != 4'd6 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("abort reached rc6", step_rc, 6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort key_ready", key_ready, 1);
        check("abort keys_ready", keys_ready, 0);
        check("abort step_start", step_start, 0);
        check("abort step_rc", step_rc, 0);
        check("abort step_key", step_key, 0);
        for (int i = 0; i <= 10; i++) read_check(i, '0, "abort");
        run_key(FIPS_KEY, 0, -1, 11, "after_abort");
        read_check(5, fips_rk[5], "after_abort");
        read_check(10, fips_rk[10], "after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
